// File: rtl/sha256_readout.sv
// SHA-256 digest readout: snapshots the 256-bit hash state on request and
// streams it out as eight 32-bit words (H0 first) over a valid/ready handshake.
// A request arriving mid-stream is dropped and flagged on a sticky overrun bit.
// The exception is a request on the same edge as the final (H7) transfer.
// That request is taken back-to-back, with no bubble between the two readouts.
module sha256_readout (
  input  logic         inclk,
  input  logic         reset_n,
  input  logic         readout_en,
  input  logic [255:0] digest,
  output logic [31:0]  dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         dout_last,
  output logic         busy,
  output logic         overrun,
  input  logic         clr_overrun
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0][31:0]  shadow_q, shadow_d;   // element 7 holds H0, element 0 holds H7
  logic              overrun_q, overrun_d;

  logic xfer, last_xfer, capture, ovr_set;

  // Next-state: capture on request when idle or on the H7 transfer, advance on transfer
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    overrun_d = overrun_q;
    capture   = 1'b0;
    ovr_set   = 1'b0;
    xfer      = (state_q == SEND) && dout_ready;
    last_xfer = xfer && (idx_q == 3'd7);

    case (state_q)
      IDLE: begin
        if (readout_en) capture = 1'b1;
      end
      SEND: begin
        if (last_xfer) begin
          if (readout_en) capture = 1'b1;
          else            state_d = IDLE;
        end else begin
          if (xfer)       idx_d   = idx_q + 3'd1;
          if (readout_en) ovr_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      shadow_d = digest;
      idx_d    = 3'd0;
      state_d  = SEND;
    end

    // a new drop beats a simultaneous clear
    if (ovr_set)          overrun_d = 1'b1;
    else if (clr_overrun) overrun_d = 1'b0;
  end

  // State registers, cleared asynchronously
  always_ff @(posedge inclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      shadow_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      overrun_q <= overrun_d;
    end
  end

  // Outputs decode straight from flops so reset clears them without waiting for a clock
  always_comb begin
    dout_valid = (state_q == SEND);
    dout       = dout_valid ? shadow_q[3'd7 - idx_q] : 32'd0;
    dout_last  = dout_valid && (idx_q == 3'd7);
    busy       = dout_valid;
    overrun    = overrun_q;
  end

endmodule

// File: tb/tb_sha256_readout.sv
// Bench for sha256_readout. The reference model keeps the words still to be
// delivered in a queue. A request either refills an empty queue or counts as
// dropped.
module tb_sha256_readout;

  logic         inclk = 1'b0;
  logic         reset_n = 1'b0;
  logic         readout_en = 1'b0;
  logic [255:0] digest = '0;
  logic [31:0]  dout;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic         dout_last;
  logic         busy;
  logic         overrun;
  logic         clr_overrun = 1'b0;

  int pass_cnt = 0;
  int total    = 0;

  logic [31:0] q[$];
  bit          m_ovr = 1'b0;
  logic [31:0] e_dout;
  bit          e_valid, e_last;

  logic [255:0] iv = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  logic [255:0] ones = {256{1'b1}};

  sha256_readout dut (
    .inclk(inclk), .reset_n(reset_n), .readout_en(readout_en), .digest(digest),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
    .busy(busy), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 inclk = ~inclk;

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [31:0] word_of(input logic [255:0] d, input int i);
    return d[255 - 32*i -: 32];
  endfunction

  function automatic void model_expect();
    e_valid = (q.size() != 0);
    e_dout  = e_valid ? q[0] : 32'd0;
    e_last  = (q.size() == 1);
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, settle past the edge
  task automatic step(input bit en, input bit rdy, input bit clr, input logic [255:0] dg);
    bit set;
    readout_en = en; dout_ready = rdy; clr_overrun = clr; digest = dg;
    @(posedge inclk);
    set = 1'b0;
    if (q.size() != 0 && rdy) void'(q.pop_front());
    if (en) begin
      if (q.size() == 0) for (int i = 0; i < 8; i++) q.push_back(word_of(dg, i));
      else set = 1'b1;
    end
    if (set) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    model_expect();
    #1;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({dout, dout_valid, dout_last, busy, overrun} !== 36'd0)
      $display("FAIL reset_state: got dout=%h v=%b l=%b b=%b o=%b exp all 0",
               dout, dout_valid, dout_last, busy, overrun);
    else pass_cnt++;
    @(negedge inclk) reset_n = 1'b1;
    // first edge after release takes the request
    step(1, 0, 0, iv);
    total++;
    if (dout_valid !== 1'b1 || dout !== 32'h6a09e667)
      $display("FAIL first_edge_accept: got v=%b dout=%h exp v=1 dout=6a09e667", dout_valid, dout);
    else pass_cnt++;
    while (q.size() != 0) step(0, 1, 0, iv);
    total++;
    if (dout_valid !== 1'b0)
      $display("FAIL reset_drain: got v=%b exp 0", dout_valid);
    else pass_cnt++;
  endtask

  task automatic test_in_order();
    logic [31:0] k;
    step(1, 1, 0, iv);
    for (int i = 0; i < 8; i++) begin
      k = word_of(iv, i);
      total++;
      if (dout !== k || dout_valid !== 1'b1 || busy !== 1'b1 || dout_last !== (i == 7))
        $display("FAIL case1_word%0d: got dout=%h v=%b b=%b l=%b exp dout=%h v=1 b=1 l=%b",
                 i, dout, dout_valid, busy, dout_last, k, (i == 7));
      else pass_cnt++;
      step(0, 1, 0, iv);
    end
    total++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 || dout !== 32'd0)
      $display("FAIL case1_idle: got v=%b b=%b dout=%h exp 0 0 0", dout_valid, busy, dout);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int n = 0;
    step(1, 0, 0, iv);
    while (q.size() != 0 && n < 60) begin
      step(0, pat[n % 4], 0, '0);   // digest zeroed after capture must not leak
      n++;
      total++;
      if (dout !== e_dout || dout_valid !== e_valid || dout_last !== e_last || busy !== e_valid)
        $display("FAIL case2_stall%0d: got dout=%h v=%b l=%b exp dout=%h v=%b l=%b",
                 n, dout, dout_valid, dout_last, e_dout, e_valid, e_last);
      else pass_cnt++;
    end
    total++;
    if (q.size() != 0 || dout_valid !== 1'b0)
      $display("FAIL case2_timeout: got v=%b pending=%0d exp idle", dout_valid, q.size());
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    step(1, 1, 0, iv);
    for (int i = 0; i < 3; i++) step(0, 1, 0, iv);
    step(1, 1, 0, ones);   // request at index 3 is dropped
    total++;
    if (overrun !== 1'b1 || dout !== 32'h510e527f)
      $display("FAIL case3_drop: got o=%b dout=%h exp o=1 dout=510e527f", overrun, dout);
    else pass_cnt++;
    // a clear and a new drop on the same edge leave overrun set
    step(1, 0, 1, ones);
    total++;
    if (overrun !== 1'b1 || dout !== 32'h510e527f)
      $display("FAIL case3_set_wins: got o=%b dout=%h exp o=1 dout=510e527f", overrun, dout);
    else pass_cnt++;
    while (q.size() != 0) begin
      step(0, 1, 0, ones);
      total++;
      if (dout !== e_dout || dout_last !== e_last || overrun !== 1'b1)
        $display("FAIL case3_stream: got dout=%h l=%b o=%b exp dout=%h l=%b o=1",
                 dout, dout_last, overrun, e_dout, e_last);
      else pass_cnt++;
    end
    step(0, 0, 1, ones);
    total++;
    if (overrun !== 1'b0)
      $display("FAIL case3_clear: got o=%b exp 0", overrun);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    step(1, 1, 0, iv);
    for (int i = 0; i < 7; i++) step(0, 1, 0, iv);
    total++;
    if (dout_last !== 1'b1 || dout !== 32'h5be0cd19)
      $display("FAIL case4_at_h7: got l=%b dout=%h exp l=1 dout=5be0cd19", dout_last, dout);
    else pass_cnt++;
    step(1, 1, 0, ones);
    total++;
    if (dout !== 32'hffffffff || dout_valid !== 1'b1 || overrun !== 1'b0 || dout_last !== 1'b0)
      $display("FAIL case4_b2b: got dout=%h v=%b o=%b l=%b exp ffffffff 1 0 0",
               dout, dout_valid, overrun, dout_last);
    else pass_cnt++;
    while (q.size() != 0) step(0, 1, 0, iv);
  endtask

  task automatic test_async_reset();
    step(1, 1, 0, iv);
    for (int i = 0; i < 5; i++) step(0, 1, 0, iv);
    total++;
    if (dout !== 32'h9b05688c)
      $display("FAIL case5_at_w5: got dout=%h exp 9b05688c", dout);
    else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    q.delete(); m_ovr = 1'b0;
    total++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 || dout !== 32'd0 || dout_last !== 1'b0)
      $display("FAIL case5_immediate: got v=%b b=%b dout=%h l=%b exp all 0",
               dout_valid, busy, dout, dout_last);
    else pass_cnt++;
    @(negedge inclk) reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(0, 1'($urandom_range(0, 1)), 0, iv);
      total++;
      if (dout_valid !== 1'b0 || dout !== 32'd0)
        $display("FAIL case5_stays_idle%0d: got v=%b dout=%h exp 0", i, dout_valid, dout);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    bit en, rdy, clr;
    for (int n = 0; n < 400; n++) begin
      en  = ($urandom_range(0, 5) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 7) == 0);
      step(en, rdy, clr, rand256());
      total++;
      if (dout !== e_dout || dout_valid !== e_valid || dout_last !== e_last ||
          busy !== e_valid || overrun !== m_ovr)
        $display("FAIL random%0d: got dout=%h v=%b l=%b b=%b o=%b exp dout=%h v=%b l=%b b=%b o=%b",
                 n, dout, dout_valid, dout_last, busy, overrun,
                 e_dout, e_valid, e_last, e_valid, m_ovr);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_stall();
    test_overrun();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/sha256_readout.md
SHA256_READOUT -- requirements
Module: sha256_readout

Interface
REQ-001 SHALL provide port: inclk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide port: reset_n  input  1  asynchronous active-low reset.
REQ-003 SHALL provide port: readout_en  input  1  one-cycle request from round control to unload the current digest.
REQ-004 SHALL provide port: digest  input  256  hash state H0..H7, H0 in bits [255:224], H7 in bits [31:0].
REQ-005 SHALL provide port: dout  output  32  current digest word.
REQ-006 SHALL provide port: dout_valid  output  1  dout holds a valid word.
REQ-007 SHALL provide port: dout_ready  input  1  consumer accepts the word on a cycle where dout_valid=1.
REQ-008 SHALL provide port: dout_last  output  1  current word is H7.
REQ-009 SHALL provide port: busy  output  1  readout in progress.
REQ-010 SHALL provide port: overrun  output  1  sticky flag: a request was dropped.
REQ-011 SHALL provide port: clr_overrun  input  1  synchronous clear of overrun.

Function
REQ-012 SHALL implement two states: IDLE and SEND.
REQ-013 In IDLE, readout_en=1 at a rising edge SHALL capture all 256 digest bits into an internal shadow register, set word index to 0, and enter SEND.
REQ-014 After that edge, digest changes SHALL NOT affect output words of the current readout.
REQ-015 dout_valid SHALL equal 1 exactly when in SEND; first word valid the cycle after the capturing edge (latency 1).
REQ-016 In SEND, dout SHALL equal shadow word[index] (index 0 = H0); dout SHALL be 0 in IDLE.
REQ-017 A transfer SHALL occur on each rising edge with dout_valid=1 and dout_ready=1.
REQ-018 While dout_valid=1 and dout_ready=0, dout, dout_last and the index SHALL hold stable.
REQ-019 On a transfer with index<7, the index SHALL increment by 1 (3-bit, no wrap inside one readout).
REQ-020 On a transfer with index=7, the block SHALL return to IDLE, unless REQ-023 applies.
REQ-021 dout_last SHALL equal 1 exactly when dout_valid=1 and index=7.
REQ-022 busy SHALL equal dout_valid.
REQ-023 readout_en=1 at the same edge as the index-7 transfer SHALL be accepted: recapture the digest, set index to 0, remain in SEND (back-to-back, no bubble, no overrun).
REQ-024 readout_en=1 in SEND at any other edge SHALL be ignored (shadow and index unchanged) and SHALL set overrun.
REQ-025 overrun SHALL stay 1 until a rising edge with clr_overrun=1 clears it.
REQ-026 If clr_overrun=1 and a new overrun event occur at the same edge, overrun SHALL be 1 (set wins).
REQ-027 An uninterrupted readout with dout_ready held at 1 SHALL take exactly 8 cycles from first dout_valid to return to IDLE.
REQ-028 dout_ready SHALL be ignored in IDLE.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE, index 0, shadow 0, dout 0, dout_valid 0, dout_last 0, busy 0, overrun 0, regardless of inclk.
REQ-030 Reset asserted mid-readout SHALL abandon the readout; after release, no further words SHALL appear without a new readout_en.
REQ-031 The first rising edge after reset_n deasserts SHALL be able to accept readout_en.

Verification
REQ-032 Case 1: digest H0..H7 = 0x6a09e667..0x5be0cd19, pulse readout_en, dout_ready=1 -> 8 consecutive valid cycles carrying H0..H7 in order, dout_last=1 only with 0x5be0cd19, then IDLE.
REQ-033 Case 2: same digest, dout_ready toggled 1,0,0,1,... -> each word held stable while stalled; no word skipped or duplicated; digest changed to 0 after capture does not alter the outputs.
REQ-034 Case 3: readout_en pulsed at word index 3 -> overrun=1, stream continues unchanged to H7; clr_overrun pulse -> overrun=0.
REQ-035 Case 4: readout_en coincident with the H7 transfer, new digest all 0xFFFFFFFF -> next cycle dout=0xFFFFFFFF, dout_valid stays 1, overrun=0.
REQ-036 Case 5: reset_n pulled low between edges at word 5 -> dout_valid, busy and dout go 0 immediately; after release, outputs stay idle until a new readout_en.
